// File: rtl/miniled_pkg.sv
// miniled_pkg: shared sizes, FSM state encoding and gray-to-PWM expansion for the zone SDI streamer
package miniled_pkg;
  localparam int ZONES      = 360;
  localparam int SCAN_LINES = 4;
  localparam int ZPS        = ZONES / SCAN_LINES;
  localparam int DCLK_DIV   = 4;
  localparam int LINE_GAP   = 8;
  localparam int WORD_W     = 16;
  localparam int GRAY_W     = 8;
  localparam int ADDR_W     = $clog2(ZONES);
  localparam int LINE_W     = $clog2(SCAN_LINES);
  localparam int ZONE_W     = $clog2(ZPS + 1);
  localparam int BIT_W      = $clog2(WORD_W);
  localparam int DIV_W      = $clog2(DCLK_DIV);
  localparam int GAP_W      = $clog2(LINE_GAP);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP, DONE} state_t;

  // Replicating the byte maps 0x00->0x0000 and 0xFF->0xFFFF (g*257)
  function automatic logic [WORD_W-1:0] expand_gray(input logic [GRAY_W-1:0] g);
    return {g, g};
  endfunction
endpackage

// File: rtl/sdi_word_shifter.sv
// sdi_word_shifter: serialises 16-bit words MSB first on DCLK/SDI/LE and flags word boundaries
module sdi_word_shifter
  import miniled_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              ld_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] nxt_word_i,
  output logic              dclk_o,
  output logic              sdi_o,
  output logic              le_o,
  output logic              first_o,
  output logic              last_o
);
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              period_end;

  // Divider steps every cycle; the bit index and shift register move only at the end of a DCLK period
  always_comb begin
    period_end = en_i && div_q == DIV_W'(DCLK_DIV - 1);
    div_d      = ld_i ? '0 : en_i ? (period_end ? '0 : div_q + 1'b1) : div_q;
    bit_d      = ld_i ? BIT_W'(WORD_W - 1) : period_end ? bit_q - 1'b1 : bit_q;
    sr_d       = ld_i ? word_i : period_end ? (bit_q == '0 ? nxt_word_i : {sr_q[WORD_W-2:0], 1'b0}) : sr_q;
    dclk_o     = en_i && div_q >= DIV_W'(DCLK_DIV / 2);
    sdi_o      = en_i && sr_q[WORD_W-1];
    le_o       = en_i && bit_q == '0;
    first_o    = en_i && bit_q == BIT_W'(WORD_W - 1) && div_q == '0;
    last_o     = period_end && bit_q == '0;
  end

  // Shift state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      div_q <= '0;
      bit_q <= '0;
    end else begin
      sr_q  <= sr_d;
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end
endmodule

// File: rtl/zone_sdi_streamer.sv
// zone_sdi_streamer: reads 360 zone grays per frame and shifts them as 16-bit words into the LED driver chain (DAISY_REVERSE_EN reverses zone order per line)
module zone_sdi_streamer
  import miniled_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              frame_start,
  output logic              rd_buf_en,
  output logic [ADDR_W-1:0] array_map,
  input  logic [GRAY_W-1:0] gray_data,
  output logic              DCLK,
  output logic              SDI,
  output logic              LE,
  output logic [LINE_W-1:0] scan_sel,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ZONE_W-1:0] zone_q, zone_d;
  logic              fcnt_q, fcnt_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              pre_q, pre_d;
  logic [WORD_W-1:0] nxt_q, nxt_d;
  logic [ZONE_W-1:0] rd_k;
  logic              sh_en, sh_ld, first, last;
  logic              start, last_zone, line_end, gap_end, last_line;

  function automatic logic [ADDR_W-1:0] zone_addr(input logic [LINE_W-1:0] l, input logic [ZONE_W-1:0] k);
`ifdef DAISY_REVERSE_EN
    return ADDR_W'(l) * ADDR_W'(ZPS) + ADDR_W'(ZPS - 1 - int'(k));
`else
    return ADDR_W'(l) * ADDR_W'(ZPS) + ADDR_W'(k);
`endif
  endfunction

  sdi_word_shifter u_shifter (
    .clk       (I_clk),
    .rst       (I_rst),
    .en_i      (sh_en),
    .ld_i      (sh_ld),
    .word_i    (expand_gray(gray_data)),
    .nxt_word_i(nxt_q),
    .dclk_o    (DCLK),
    .sdi_o     (SDI),
    .le_o      (LE),
    .first_o   (first),
    .last_o    (last)
  );

  // Next-state, buffer addressing and status decode; the next word is fetched while bit 15 of the current one is out
  always_comb begin
    start     = frame_start && (state_q == IDLE || state_q == DONE);
    last_zone = zone_q == ZONE_W'(ZPS - 1);
    line_end  = last && last_zone;
    gap_end   = gcnt_q == GAP_W'(LINE_GAP - 1);
    last_line = line_q == LINE_W'(SCAN_LINES - 1);
    sh_en     = state_q == SHIFT;
    sh_ld     = state_q == FETCH && fcnt_q;
    rd_buf_en = (state_q == FETCH && !fcnt_q) || (first && !last_zone);
    rd_k      = state_q == FETCH ? '0 : zone_q + 1'b1;
    array_map = rd_buf_en ? zone_addr(line_q, rd_k) : '0;
    busy      = state_q == FETCH || state_q == SHIFT || state_q == GAP;
    done      = state_q == DONE;
    scan_sel  = busy ? line_q : '0;
    state_d   = state_q;
    unique case (state_q)
      IDLE:    state_d = frame_start ? FETCH : IDLE;
      FETCH:   state_d = fcnt_q ? SHIFT : FETCH;
      SHIFT:   state_d = line_end ? GAP : SHIFT;
      GAP:     state_d = gap_end ? (last_line ? DONE : FETCH) : GAP;
      DONE:    state_d = frame_start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
    line_d = start ? '0 : (state_q == GAP && gap_end && !last_line) ? line_q + 1'b1 : line_q;
    zone_d = (start || state_q == GAP) ? '0 : last ? zone_q + 1'b1 : zone_q;
    fcnt_d = state_q == FETCH && !fcnt_q;
    gcnt_d = state_q == GAP ? gcnt_q + 1'b1 : '0;
    pre_d  = sh_en && rd_buf_en;
    nxt_d  = pre_q ? expand_gray(gray_data) : nxt_q;
  end

  // Control registers; reset drops every output to 0 at once
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      zone_q  <= '0;
      fcnt_q  <= 1'b0;
      gcnt_q  <= '0;
      pre_q   <= 1'b0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      zone_q  <= zone_d;
      fcnt_q  <= fcnt_d;
      gcnt_q  <= gcnt_d;
      pre_q   <= pre_d;
      nxt_q   <= nxt_d;
    end
  end

  // Reads must always land inside the zone buffer
  assert property (@(posedge I_clk) disable iff (I_rst) rd_buf_en |-> array_map < ADDR_W'(ZONES));
endmodule
